// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
// State encoding, key codes and the BCD time register layout.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min_t;
    bcd_t min_o;
    bcd_t sec_t;
    bcd_t sec_o;
  } mmss_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_ALARM = 2'd3;

  localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;
  localparam logic [4:0] KEY_START     = 5'd10;
  localparam logic [4:0] KEY_STOP      = 5'd11;
  localparam logic [4:0] KEY_CLEAR     = 5'd12;

endpackage

// File: rtl/bcd_mmss_dec.sv
// MM:SS BCD decrement by one second, with a flag for a 00:00 result.
// Latency: combinational. Backpressure: none, pure function of the input.
import timer_pkg::*;

module bcd_mmss_dec (
  input  mmss_t cur_dat,
  output mmss_t nxt_dat,
  output logic  zero
);

  always_comb begin
    nxt_dat = cur_dat;
    if (cur_dat.sec_o != 4'd0) begin
      nxt_dat.sec_o = cur_dat.sec_o - 4'd1;
    end else begin
      nxt_dat.sec_o = 4'd9;
      if (cur_dat.sec_t != 4'd0) begin
        nxt_dat.sec_t = cur_dat.sec_t - 4'd1;
      end else begin
        nxt_dat.sec_t = 4'd5;
        if (cur_dat.min_o != 4'd0) begin
          nxt_dat.min_o = cur_dat.min_o - 4'd1;
        end else begin
          nxt_dat.min_o = 4'd9;
          nxt_dat.min_t = cur_dat.min_t - 4'd1;
        end
      end
    end
  end

  assign zero = (nxt_dat == '0);

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: key entry, run/pause, alarm; owns the MM:SS register.
// Latency: key/tick effect on outputs one edge later. Backpressure: none, keys are strobes.
// Optional TIMER_CTRL_RELOAD_EN: preset latched at START and restored on alarm exit / CLEAR.
import timer_pkg::*;

module timer_ctrl #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int ALARM_SEC     = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pls_1k,
  input  logic       i_key_valid,
  input  logic [4:0] i_key_data,
  output logic [3:0] o_min_t,
  output logic [3:0] o_min_o,
  output logic [3:0] o_sec_t,
  output logic [3:0] o_sec_o,
  output logic [1:0] o_state,
  output logic       o_alarm
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

  logic [1:0]    state;
  mmss_t         tm;
  mmss_t         tm_dec;
  mmss_t         reload_val;
  logic          dec_zero;
  logic [PW-1:0] presc;
  logic [AW-1:0] acnt;

  logic key_ok, key_digit, key_start, key_stop, key_clear, sec_tick;

  assign key_ok    = i_key_valid && (i_key_data <= KEY_CLEAR);
  assign key_digit = key_ok && (i_key_data <= KEY_DIGIT_MAX);
  assign key_start = key_ok && (i_key_data == KEY_START);
  assign key_stop  = key_ok && (i_key_data == KEY_STOP);
  assign key_clear = key_ok && (i_key_data == KEY_CLEAR);
  assign sec_tick  = i_pls_1k && (presc == PW'(TICKS_PER_SEC - 1));

  bcd_mmss_dec u_dec (
    .cur_dat (tm),
    .nxt_dat (tm_dec),
    .zero    (dec_zero)
  );

`ifdef TIMER_CTRL_RELOAD_EN
  mmss_t preset;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      preset <= '0;
    end else if (state == ST_IDLE) begin
      if (key_start && tm != '0) preset <= tm;
      else if (key_clear)        preset <= '0;
    end
  end

  assign reload_val = preset;
`else
  assign reload_val = '0;
`endif

  // Keys are decoded ahead of the prescaler so a coincident tick is dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      tm    <= '0;
      presc <= '0;
      acnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_digit) begin
            if (tm.sec_o <= 4'd5) tm <= {tm.min_o, tm.sec_t, tm.sec_o, i_key_data[3:0]};
          end else if (key_start && tm != '0) begin
            state <= ST_RUN;
            presc <= '0;
          end else if (key_clear) begin
            tm <= '0;
          end
        end
        ST_RUN: begin
          if (key_stop) begin
            state <= ST_PAUSE;
          end else if (key_clear) begin
            state <= ST_IDLE;
            tm    <= reload_val;
          end else if (sec_tick) begin
            presc <= '0;
            tm    <= tm_dec;
            if (dec_zero) begin
              state <= ST_ALARM;
              acnt  <= '0;
            end
          end else if (i_pls_1k) begin
            presc <= presc + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (key_start) begin
            state <= ST_RUN;
          end else if (key_clear) begin
            state <= ST_IDLE;
            tm    <= reload_val;
          end
        end
        default: begin
          if (key_ok) begin
            state <= ST_IDLE;
            tm    <= reload_val;
            acnt  <= '0;
            presc <= '0;
          end else if (sec_tick) begin
            presc <= '0;
            if (acnt == AW'(ALARM_SEC - 1)) begin
              state <= ST_IDLE;
              tm    <= reload_val;
              acnt  <= '0;
            end else begin
              acnt <= acnt + AW'(1);
            end
          end else if (i_pls_1k) begin
            presc <= presc + PW'(1);
          end
        end
      endcase
    end
  end

  assign o_min_t = tm.min_t;
  assign o_min_o = tm.min_o;
  assign o_sec_t = tm.sec_t;
  assign o_sec_o = tm.sec_o;
  assign o_state = state;
  assign o_alarm = (state == ST_ALARM);

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: seconds-based reference model compared every cycle, plus literal checks.
module tb_timer_ctrl;

  localparam int TPS = 4;
  localparam int ASEC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pls = 1'b0;
  logic       kv  = 1'b0;
  logic [4:0] kd  = 5'd0;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic [1:0] st;
  logic       alarm;

  int nvec = 0;
  int nfail = 0;
  bit done = 1'b0;

  timer_ctrl #(.TICKS_PER_SEC(TPS), .ALARM_SEC(ASEC)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pls_1k    (pls),
    .i_key_valid (kv),
    .i_key_data  (kd),
    .o_min_t     (min_t),
    .o_min_o     (min_o),
    .o_sec_t     (sec_t),
    .o_sec_o     (sec_o),
    .o_state     (st),
    .o_alarm     (alarm)
  );

  always #5 clk = ~clk;

  // Model: time held as total seconds; state 0 idle, 1 run, 2 pause, 3 alarm.
  typedef struct packed {
    logic [1:0]  st;
    logic [15:0] secs;
    logic [15:0] pre;
    logic [15:0] acnt;
    logic [15:0] preset;
  } mdl_t;

  mdl_t m;

  function automatic logic [15:0] reload_secs(mdl_t s);
`ifdef TIMER_CTRL_RELOAD_EN
    return s.preset;
`else
    return 16'd0;
`endif
  endfunction

  function automatic mdl_t step_f(mdl_t s, logic v, logic [4:0] k, logic p);
    mdl_t r = s;
    int mins = int'(s.secs) / 60;
    int secs = int'(s.secs) % 60;
    bit valid = v && (k <= 5'd12);
    bit tick = p && (int'(s.pre) == TPS - 1);
    case (s.st)
      2'd0: if (valid) begin
        if (k <= 5'd9) begin
          if (secs % 10 <= 5)
            r.secs = 16'(((mins % 10) * 10 + secs / 10) * 60 + (secs % 10) * 10 + int'(k));
        end else if (k == 5'd10 && s.secs != 0) begin
          r.st = 2'd1; r.pre = 0; r.preset = s.secs;
        end else if (k == 5'd12) begin
          r.secs = 0; r.preset = 0;
        end
      end
      2'd1: begin
        if (valid && k == 5'd11) r.st = 2'd2;
        else if (valid && k == 5'd12) begin r.st = 2'd0; r.secs = reload_secs(s); end
        else if (tick) begin
          r.pre = 0; r.secs = s.secs - 16'd1;
          if (r.secs == 0) begin r.st = 2'd3; r.acnt = 0; end
        end else if (p) r.pre = s.pre + 16'd1;
      end
      2'd2: begin
        if (valid && k == 5'd10) r.st = 2'd1;
        else if (valid && k == 5'd12) begin r.st = 2'd0; r.secs = reload_secs(s); end
      end
      default: begin
        if (valid) begin
          r.st = 2'd0; r.secs = reload_secs(s); r.acnt = 0; r.pre = 0;
        end else if (tick) begin
          r.pre = 0;
          if (int'(s.acnt) == ASEC - 1) begin r.st = 2'd0; r.secs = reload_secs(s); r.acnt = 0; end
          else r.acnt = s.acnt + 16'd1;
        end else if (p) r.pre = s.pre + 16'd1;
      end
    endcase
    return r;
  endfunction

  function automatic logic [15:0] bcd_of(logic [15:0] s);
    int mn = int'(s) / 60;
    int sc = int'(s) % 60;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= step_f(m, kv, kd, pls);
  end

  always @(negedge clk) begin
    if (!done) begin
      nvec++;
      if ({min_t, min_o, sec_t, sec_o} != bcd_of(m.secs) || st != m.st || alarm != (m.st == 2'd3)) begin
        nfail++;
        $display("FAIL model t=%0t got %h st=%0d al=%0b want %h st=%0d al=%0b", $time,
                 {min_t, min_o, sec_t, sec_o}, st, alarm, bcd_of(m.secs), m.st, m.st == 2'd3);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    nvec++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  function automatic int disp();
    return int'({min_t, min_o, sec_t, sec_o});
  endfunction

  task automatic cyc(input logic v, input logic [4:0] k, input logic p);
    kv = v; kd = k; pls = p;
    @(negedge clk);
    kv = 1'b0; kd = 5'd0; pls = 1'b0;
  endtask

  task automatic key(input logic [4:0] k);
    cyc(1'b1, k, 1'b0);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_digits", disp(), 'h0000);
    chk("reset_state", int'(st), 0);
    rst = 1'b0;
    @(negedge clk);

    key(5'd1); key(5'd2); key(5'd3); key(5'd0);
    chk("entry_1230", disp(), 'h1230);
    key(5'd7);
    chk("entry_2307", disp(), 'h2307);
    key(5'd4);
    chk("entry_reject", disp(), 'h2307);
    key(5'd20); key(5'd11);
    chk("ignored_keys", disp(), 'h2307);

    key(5'd12); key(5'd3);
    cyc(1'b1, 5'd10, 1'b1);
    chk("start_run", int'(st), 1);
    pulses(TPS - 1);
    chk("no_tick_yet", disp(), 'h0003);
    pulses(1);
    chk("first_dec", disp(), 'h0002);
    pulses(2 * TPS);
    chk("alarm_state", int'(st), 3);
    chk("alarm_flag", int'(alarm), 1);
    pulses(ASEC * TPS - 1);
    chk("alarm_hold", int'(alarm), 1);
    pulses(1);
    chk("alarm_timeout", int'(st), 0);

    key(5'd12);
    key(5'd1); key(5'd0); key(5'd0); key(5'd0);
    key(5'd10);
    pulses(TPS);
    chk("borrow_1000", disp(), 'h0959);
    key(5'd12); key(5'd12);
    key(5'd1); key(5'd0); key(5'd0);
    key(5'd10);
    pulses(TPS);
    chk("borrow_0100", disp(), 'h0059);

    pulses(2);
    key(5'd11);
    pulses(3000);
    chk("pause_frozen", disp(), 'h0059);
    chk("pause_state", int'(st), 2);
    key(5'd10);
    pulses(1);
    chk("resume_held", disp(), 'h0059);
    pulses(1);
    chk("resume_dec", disp(), 'h0058);

    pulses(TPS - 1);
    cyc(1'b1, 5'd11, 1'b1);
    chk("stop_vs_tick", disp(), 'h0058);
    chk("stop_vs_tick_st", int'(st), 2);
    key(5'd12); key(5'd12);

    key(5'd5);
    key(5'd10);
    pulses(5 * TPS);
    chk("reload_alarm", int'(st), 3);
    key(5'd3);
`ifdef TIMER_CTRL_RELOAD_EN
    chk("reload_exit", disp(), 'h0005);
`else
    chk("reload_exit", disp(), 'h0000);
`endif

    key(5'd12); key(5'd1); key(5'd10);
    pulses(TPS);
    chk("pre_reset_alarm", int'(alarm), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_alarm_drop", int'(alarm), 0);
    chk("async_digits", disp(), 'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout bench did not complete");
    $fatal(1);
  end

endmodule
